apb_fsm_controller: RTL

APB_FSM_CONTROLLER -- requirements
Module: apb_fsm_controller

---
 rtl/apb_fsm_controller_pkg.sv | 37 +++
 rtl/apb_fsm_controller.sv | 125 ++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller_pkg.sv
// Shared definitions for the AHB-to-APB bridge FSM: state encoding, slave address map, HTRANS codes.
// Also provides the address-to-select decode used when a pipelined write re-derives its slave.
package apb_fsm_controller_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WWAIT    = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_WRITEP   = 3'd4;
  localparam logic [2:0] ST_RENABLE  = 3'd5;
  localparam logic [2:0] ST_WENABLE  = 3'd6;
  localparam logic [2:0] ST_WENABLEP = 3'd7;

  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] SLV_END   = 32'h8c00_0000;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // One-hot slave select for an address; zero outside the mapped window.
  function automatic logic [2:0] addr_to_sel(input logic [31:0] addr);
    logic [2:0] sel;
    sel = 3'b000;
    if (addr >= SLV0_BASE && addr < SLV1_BASE)
      sel = 3'b001;
    else if (addr >= SLV1_BASE && addr < SLV2_BASE)
      sel = 3'b010;
    else if (addr >= SLV2_BASE && addr < SLV_END)
      sel = 3'b100;
    return sel;
  endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge FSM: every APB transfer is one setup plus one enable cycle, outputs registered.
// Reads reach Penable two cycles after valid; Hreadyout drops only in READ/WRITEP setup cycles.
module apb_fsm_controller
  import apb_fsm_controller_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        valid,
  input  logic        Hwrite,
  input  logic        Hwritereg,
  input  logic [31:0] Haddr,
  input  logic [31:0] Haddr1,
  input  logic [31:0] Haddr2,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Hwdata1,
  input  logic [2:0]  tempselx,
  input  logic [31:0] Prdata,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout
);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [2:0] sel_latch;
  logic [2:0] sel_pipe;

  // Read data travels straight from the slave to the AHB side outside this block.
  logic unused_prdata;
  assign unused_prdata = ^Prdata;

  assign sel_pipe = addr_to_sel((state == ST_WWAIT) ? Haddr1 : Haddr2);

  always_ff @(posedge Hclk) begin
    if (Hreset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!valid)      next_state = ST_IDLE;
        else if (Hwrite) next_state = ST_WWAIT;
        else             next_state = ST_READ;
      end
      ST_WWAIT:    next_state = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     next_state = ST_RENABLE;
      ST_WRITE:    next_state = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   next_state = ST_WENABLEP;
      ST_RENABLE,
      ST_WENABLE: begin
        if (!valid)      next_state = ST_IDLE;
        else if (Hwrite) next_state = ST_WWAIT;
        else             next_state = ST_READ;
      end
      ST_WENABLEP: begin
        if (!Hwritereg)  next_state = ST_READ;
        else if (valid)  next_state = ST_WRITEP;
        else             next_state = ST_WRITE;
      end
      default:     next_state = ST_IDLE;
    endcase
  end

  // Outputs are loaded from the state being entered, so they line up with it.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Pselx     <= 3'b000;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= 32'h0;
      Pwdata    <= 32'h0;
      Hreadyout <= 1'b1;
      sel_latch <= 3'b000;
    end else begin
      if (next_state == ST_WWAIT)
        sel_latch <= tempselx;
      case (next_state)
        ST_READ: begin
          Pselx     <= tempselx;
          Paddr     <= Haddr;
          Pwrite    <= 1'b0;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end
        ST_WRITE: begin
          Pselx     <= sel_latch;
          Paddr     <= Haddr1;
          Pwdata    <= Hwdata;
          Pwrite    <= 1'b1;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
        end
        ST_WRITEP: begin
          // The first pipelined write still sits one stage back; later ones are two stages back.
          sel_latch <= sel_pipe;
          Pselx     <= sel_pipe;
          Paddr     <= (state == ST_WWAIT) ? Haddr1 : Haddr2;
          Pwdata    <= (state == ST_WWAIT) ? Hwdata : Hwdata1;
          Pwrite    <= 1'b1;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP: begin
          Penable   <= 1'b1;
          Hreadyout <= 1'b1;
        end
        default: begin
          Pselx     <= 3'b000;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule
